// File: rtl/set_clock_pkg.sv
// Shared types and BCD limits for the time-set logic (button FSM states, digit bounds).
// Used by set_button and set_clock_ctrl.
package set_clock_pkg;

    typedef enum logic [2:0] {
        BTN_IDLE      = 3'd0,
        BTN_DEB_PRESS = 3'd1,
        BTN_HELD_DLY  = 3'd2,
        BTN_HELD_REP  = 3'd3,
        BTN_DEB_REL   = 3'd4
    } btn_state_t;

    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [3:0] UNIT_MAX      = 4'd9;
    localparam logic [3:0] H24_MAX_TENS  = 4'd2;
    localparam logic [3:0] H24_MAX_UNITS = 4'd3;
    localparam int unsigned H12_MAX      = 12;
    localparam logic [3:0] H12_TENS      = 4'(H12_MAX / 10);
    localparam logic [3:0] H12_UNITS     = 4'(H12_MAX % 10);

    // Single BCD digit increment that wraps to 0 once the digit has reached lim.
    function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/set_button.sv
// One push button: 2-flop synchroniser plus debounce / hold-to-repeat FSM producing step pulses.
// Hold-to-repeat is built only when AUTO_REPEAT_EN is defined; otherwise one step per press.
module set_button
    import set_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned REPEAT_DLY   = 16,
    parameter int unsigned REPEAT_PER   = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_i,
    output logic step_o
);

    if (DEBOUNCE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1 || CNT_W < 1 || CNT_W > 31 ||
        (DEBOUNCE_CYC >> CNT_W) != 0 || (REPEAT_DLY >> CNT_W) != 0 ||
        (REPEAT_PER >> CNT_W) != 0) begin : g_cfg_err
        $error("set_button: counter configuration does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] DEB_LIM_M1 = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic [1:0]       settle_q;
    logic             armed_q, armed_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_q, step_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PER);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    btn_state_t       ret_q, ret_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_cnt_q <= '0;
            ret_q     <= BTN_HELD_DLY;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            ret_q     <= ret_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            settle_q  <= 2'b00;
            armed_q   <= 1'b0;
            state_q   <= BTN_IDLE;
            deb_cnt_q <= '0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_n_i;
            sync2_q   <= sync1_q;
            settle_q  <= {settle_q[0], 1'b1};
            armed_q   <= armed_d;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        armed_d   = armed_q;
        step_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        ret_d     = ret_q;
`endif
        case (state_q)
            BTN_IDLE: begin
                // After reset a press is only accepted once a debounced release has been seen,
                // so a button still held through reset cannot generate a step.
                if (!armed_q) begin
                    if (settle_q[1] && sync2_q) begin
                        if (deb_cnt_q >= DEB_LIM_M1) begin
                            armed_d   = 1'b1;
                            deb_cnt_d = '0;
                        end else begin
                            deb_cnt_d = deb_cnt_q + CNT_ONE;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end else if (!sync2_q) begin
                    state_d   = BTN_DEB_PRESS;
                    deb_cnt_d = CNT_ONE;
                end
            end
            BTN_DEB_PRESS: begin
                if (sync2_q) begin
                    state_d   = BTN_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LIM) begin
                    state_d   = BTN_HELD_DLY;
                    step_d    = 1'b1;
                    deb_cnt_d = '0;
`ifdef AUTO_REPEAT_EN
                    rep_cnt_d = CNT_ONE;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            BTN_HELD_DLY: begin
                if (sync2_q) begin
                    state_d   = BTN_DEB_REL;
                    deb_cnt_d = CNT_ONE;
`ifdef AUTO_REPEAT_EN
                    ret_d     = BTN_HELD_DLY;
                end else if (rep_cnt_q >= DLY_LIM) begin
                    state_d   = BTN_HELD_REP;
                    step_d    = 1'b1;
                    rep_cnt_d = CNT_ONE;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            BTN_HELD_REP: begin
                if (sync2_q) begin
                    state_d   = BTN_DEB_REL;
                    deb_cnt_d = CNT_ONE;
                    ret_d     = BTN_HELD_REP;
                end else if (rep_cnt_q >= PER_LIM) begin
                    step_d    = 1'b1;
                    rep_cnt_d = CNT_ONE;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end
`endif
            BTN_DEB_REL: begin
                // A bounce resumes the held state; the repeat counter is left untouched.
                if (!sync2_q) begin
`ifdef AUTO_REPEAT_EN
                    state_d   = ret_q;
`else
                    state_d   = BTN_HELD_DLY;
`endif
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LIM) begin
                    state_d   = BTN_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = BTN_IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    assign step_o = step_q;

endmodule

// File: rtl/set_clock_ctrl.sv
// Time-set controller: two debounced step buttons driving BCD hour/minute set registers,
// 24h or 12h+pm display, with parallel load. Optional hold-to-repeat via AUTO_REPEAT_EN.
module set_clock_ctrl
    import set_clock_pkg::*;
#(
    parameter int unsigned HOUR_24      = 1,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned REPEAT_DLY   = 16,
    parameter int unsigned REPEAT_PER   = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       switch,
    input  logic       push2,
    input  logic       push3,
    input  logic       load,
    input  logic [3:0] ld_h1,
    input  logic [3:0] ld_h0,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_m0,
    input  logic       ld_pm,
    output logic [3:0] s0h1,
    output logic [3:0] s0h0,
    output logic [3:0] s0m1,
    output logic [3:0] s0m0,
    output logic       s0pm
);

    localparam bit         IS_24  = (HOUR_24 != 0);
    localparam logic [3:0] RST_H1 = IS_24 ? 4'd0 : H12_TENS;
    localparam logic [3:0] RST_H0 = IS_24 ? 4'd0 : H12_UNITS;

    // Index 0 is the minute button, index 1 the hour button.
    logic [1:0] btn_raw;
    logic [1:0] btn_step;

    assign btn_raw = {push3, push2};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            set_button #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .REPEAT_DLY   (REPEAT_DLY),
                .REPEAT_PER   (REPEAT_PER),
                .CNT_W        (CNT_W)
            ) u_btn (
                .clk     (clk),
                .reset_n (reset_n),
                .btn_n_i (btn_raw[gi]),
                .step_o  (btn_step[gi])
            );
        end
    endgenerate

    logic       min_step, hr_step;
    logic [3:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic       pm_q, pm_d;

    assign min_step = switch & btn_step[0];
    assign hr_step  = switch & btn_step[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h1_q <= RST_H1;
            h0_q <= RST_H0;
            m1_q <= 4'd0;
            m0_q <= 4'd0;
            pm_q <= 1'b0;
        end else begin
            h1_q <= h1_d;
            h0_q <= h0_d;
            m1_q <= m1_d;
            m0_q <= m0_d;
            pm_q <= pm_d;
        end
    end

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        pm_d = pm_q;
        if (load) begin
            h1_d = ld_h1;
            h0_d = ld_h0;
            m1_d = ld_m1;
            m0_d = ld_m0;
            pm_d = IS_24 ? 1'b0 : ld_pm;
        end else begin
            // Minutes wrap 59 -> 00 on their own; hours are never carried into.
            if (min_step) begin
                m0_d = bcd_wrap_inc(m0_q, UNIT_MAX);
                if (m0_q >= UNIT_MAX) begin
                    m1_d = bcd_wrap_inc(m1_q, MIN_TENS_MAX);
                end
            end
            if (hr_step) begin
                if (IS_24) begin
                    if (h1_q == H24_MAX_TENS && h0_q == H24_MAX_UNITS) begin
                        h1_d = 4'd0;
                        h0_d = 4'd0;
                    end else begin
                        h0_d = bcd_wrap_inc(h0_q, UNIT_MAX);
                        if (h0_q >= UNIT_MAX) begin
                            h1_d = h1_q + 4'd1;
                        end
                    end
                end else begin
                    if (h1_q == H12_TENS && h0_q == H12_UNITS) begin
                        h1_d = 4'd0;
                        h0_d = 4'd1;
                    end else if (h1_q == H12_TENS && h0_q == H12_UNITS - 4'd1) begin
                        h0_d = H12_UNITS;
                        pm_d = ~pm_q;
                    end else begin
                        h0_d = bcd_wrap_inc(h0_q, UNIT_MAX);
                        if (h0_q >= UNIT_MAX) begin
                            h1_d = h1_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign s0h1 = h1_q;
    assign s0h0 = h0_q;
    assign s0m1 = m1_q;
    assign s0m0 = m0_q;
    assign s0pm = IS_24 ? 1'b0 : pm_q;

endmodule

// File: tb/tb_set_clock_ctrl.sv
// Directed bench for set_clock_ctrl: a 24h and a 12h instance share all inputs.
// Expectations follow the AUTO_REPEAT_EN setting of the build.
module tb_set_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, switch, push2, push3, load, ld_pm;
    logic [3:0] ld_h1, ld_h0, ld_m1, ld_m0;
    logic [3:0] a_h1, a_h0, a_m1, a_m0;
    logic       a_pm;
    logic [3:0] b_h1, b_h0, b_m1, b_m0;
    logic       b_pm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    set_clock_ctrl #(
        .HOUR_24 (1), .DEBOUNCE_CYC (4), .REPEAT_DLY (16), .REPEAT_PER (8), .CNT_W (16)
    ) dut24 (
        .clk (clk), .reset_n (reset_n), .switch (switch), .push2 (push2), .push3 (push3),
        .load (load), .ld_h1 (ld_h1), .ld_h0 (ld_h0), .ld_m1 (ld_m1), .ld_m0 (ld_m0),
        .ld_pm (ld_pm), .s0h1 (a_h1), .s0h0 (a_h0), .s0m1 (a_m1), .s0m0 (a_m0), .s0pm (a_pm)
    );

    set_clock_ctrl #(
        .HOUR_24 (0), .DEBOUNCE_CYC (4), .REPEAT_DLY (16), .REPEAT_PER (8), .CNT_W (16)
    ) dut12 (
        .clk (clk), .reset_n (reset_n), .switch (switch), .push2 (push2), .push3 (push3),
        .load (load), .ld_h1 (ld_h1), .ld_h0 (ld_h0), .ld_m1 (ld_m1), .ld_m0 (ld_m0),
        .ld_pm (ld_pm), .s0h1 (b_h1), .s0h0 (b_h0), .s0m1 (b_m1), .s0m0 (b_m0), .s0pm (b_pm)
    );

    // {pm, h1, h0, m1, m0}
    function automatic logic [16:0] t24();
        return {a_pm, a_h1, a_h0, a_m1, a_m0};
    endfunction

    function automatic logic [16:0] t12();
        return {b_pm, b_h1, b_h0, b_m1, b_m0};
    endfunction

    task automatic check_value(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_time(input logic [15:0] hhmm, input logic pm);
        {ld_h1, ld_h0, ld_m1, ld_m0} = hhmm;
        ld_pm = pm;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Press for 10 cycles (one step, well short of the first repeat), then settle released.
    task automatic press(input logic do_min, input logic do_hr);
        push2 = ~do_min;
        push3 = ~do_hr;
        repeat (10) tick();
        push2 = 1'b1;
        push3 = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        logic [3:0] exp_m0;
        reset_n = 1'b0; switch = 1'b1; push2 = 1'b1; push3 = 1'b1; load = 1'b0;
        ld_h1 = '0; ld_h0 = '0; ld_m1 = '0; ld_m0 = '0; ld_pm = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check_value("reset_24", t24(), 17'h0_0000);
        check_value("reset_12", t12(), 17'h0_1200);
        repeat (10) tick();

        // Short glitch: 3 low cycles never debounces.
        push2 = 1'b0;
        repeat (3) tick();
        push2 = 1'b1;
        repeat (15) tick();
        check_value("short_press", t24(), 17'h0_0000);

        // Long hold: first step lands at edge 7, repeats at +16, +8, +8.
        push2 = 1'b0;
        for (int e = 0; e <= 60; e++) begin
            tick();
            if (e == 39) push2 = 1'b1;
            exp_m0 = (e >= 7) ? 4'd1 : 4'd0;
`ifdef AUTO_REPEAT_EN
            if (e >= 23) exp_m0++;
            if (e >= 31) exp_m0++;
            if (e >= 39) exp_m0++;
`endif
            check_value($sformatf("hold_e%0d", e), {13'h0, a_m0}, {13'h0, exp_m0});
        end

        load_time(16'h2359, 1'b0);
        check_value("load_2359", t24(), 17'h0_2359);
        press(1'b1, 1'b0);
        check_value("min_wrap_no_carry", t24(), 17'h0_2300);
        press(1'b0, 1'b1);
        check_value("hr_wrap_24", t24(), 17'h0_0000);

        load_time(16'h1130, 1'b0);
        check_value("load_12", t12(), 17'h0_1130);
        press(1'b0, 1'b1);
        check_value("hr_11_to_12_pm", t12(), 17'h1_1230);
        check_value("hr_11_to_12_24h", t24(), 17'h0_1230);
        press(1'b0, 1'b1);
        check_value("hr_12_to_01", t12(), 17'h1_0130);
        check_value("hr_12_to_13_24h", t24(), 17'h0_1330);

        load_time(16'h0959, 1'b1);
        check_value("ld_pm_ignored_24", t24(), 17'h0_0959);
        check_value("ld_pm_12", t12(), 17'h1_0959);
        push2 = 1'b0;
        push3 = 1'b0;
        repeat (7) tick();
        check_value("both_edge6", t24(), 17'h0_0959);
        tick();
        check_value("both_edge7_24", t24(), 17'h0_1000);
        check_value("both_edge7_12", t12(), 17'h1_1000);
        repeat (2) tick();
        push2 = 1'b1;
        push3 = 1'b1;
        repeat (10) tick();
        switch = 1'b0;
        press(1'b1, 1'b1);
        check_value("switch_off_24", t24(), 17'h0_1000);
        check_value("switch_off_12", t12(), 17'h1_1000);
        switch = 1'b1;

        // Load lands in the same cycle as the hour step and must win.
        push3 = 1'b0;
        repeat (7) tick();
        load_time(16'h0505, 1'b0);
        check_value("load_beats_step_24", t24(), 17'h0_0505);
        check_value("load_beats_step_12", t12(), 17'h0_0505);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_value("midhold_reset_24", t24(), 17'h0_0000);
        check_value("midhold_reset_12", t12(), 17'h0_1200);
        repeat (40) tick();
        check_value("held_after_reset", t24(), 17'h0_0000);
        push3 = 1'b1;
        repeat (20) tick();
        check_value("release_after_reset", t24(), 17'h0_0000);
        press(1'b0, 1'b1);
        check_value("repress_24", t24(), 17'h0_0100);
        check_value("repress_12", t12(), 17'h0_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_clock_ctrl.md
Name: set_clock_ctrl

Overview:
Synchronous, parametrised successor to the alarm/clock time-set logic. It converts two raw active-low push buttons into debounced step pulses with hold-to-repeat, and maintains the BCD set-time registers. Supports 24h or 12h (AM/PM) display and a parallel load from the running clock. Sits between the board buttons and the clock/alarm compare logic.

Parameters:
HOUR_24, 1, 1 = hours 00..23; 0 = hours 01..12 plus pm flag
DEBOUNCE_CYC, 4, consecutive stable synchronised cycles needed to accept a press or release (>=1)
REPEAT_DLY, 16, cycles from first step to first auto-repeat step
REPEAT_PER, 8, cycles between subsequent auto-repeat steps
CNT_W, 16, width of the internal debounce/repeat counters; must hold max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
switch  in  1  set-mode enable; steps apply only when 1
push2  in  1  raw minute button, active-low, asynchronous
push3  in  1  raw hour button, active-low, asynchronous
load  in  1  one-cycle strobe: copy ld_* into set registers
ld_h1, ld_h0, ld_m1, ld_m0  in  4 each  BCD time to load
ld_pm  in  1  pm flag to load (ignored when HOUR_24=1)
s0h1, s0h0, s0m1, s0m0  out  4 each  BCD set time
s0pm  out  1  pm flag; constant 0 when HOUR_24=1

Behaviour:
- Reset (reset_n=0 at rising clk): 24h -> 00:00; 12h -> 12:00, s0pm=0. All button FSMs to IDLE, counters 0, sync flops to 1 (released).
- Input path per button: 2-flop synchroniser, then FSM with states IDLE, DEB_PRESS, HELD_DLY, HELD_REP, DEB_REL.
- IDLE: sync low -> DEB_PRESS, count=1.
- DEB_PRESS: sync low increments count; sync high -> IDLE. Reaching DEBOUNCE_CYC -> HELD_DLY, one-cycle step pulse.
- HELD_DLY: after REPEAT_DLY cycles -> HELD_REP, step pulse. HELD_REP: step pulse every REPEAT_PER cycles.
- HELD_DLY/HELD_REP: sync high -> DEB_REL. DEB_REL: DEBOUNCE_CYC consecutive highs -> IDLE; any low returns to the previous held state with its counter preserved.
- Latency: raw fall at edge 0 -> field updates at rising edge 3+DEBOUNCE_CYC.
- Steps are gated by switch sampled in the pulse cycle. With switch=0, FSMs still run but the fields hold.
- Minute step: m0<9 -> m0+1; else m0=0 and m1 = (m1<5) ? m1+1 : 0. No carry into hours.
- Hour step, 24h: 23 -> 00, otherwise BCD increment (h0=9 -> h0=0, h1+1).
- Hour step, 12h: 12 -> 01; 11 -> 12 and s0pm toggles; otherwise BCD increment (09 -> 10).
- Simultaneous minute and hour steps: both fields update in the same cycle.
- load=1 has priority over steps in that cycle. Values are copied verbatim; the loader guarantees legal BCD.
- reset_n low mid-hold: full reset. The button must be released and pressed again to produce a step.

Optional Feature:
AUTO_REPEAT_EN. When defined, the HELD_DLY/HELD_REP repeat behaviour above is included. When undefined, the FSM emits only the first step per press; HELD_DLY waits for release and there are no repeat counters.

Decomposition:
- Package set_clock_pkg: button state enum, BCD limit constants (MIN_TENS_MAX=5, UNIT_MAX=9, H24_MAX_TENS=2, H24_MAX_UNITS=3, H12_MAX=12).
- Sub-module set_button (synchroniser + debounce/repeat FSM, outputs step pulse), instantiated twice.
- Top holds only the BCD field update logic.

Test Plan:
1. Reset, HOUR_24=1, switch=1; push2 low 3 cycles (DEBOUNCE_CYC=4) -> no step, time 00:00.
2. push2 low, held 40 cycles, AUTO_REPEAT_EN, DLY=16, PER=8 -> s0m0 becomes 1 at edge 7, then 2, 3, 4 at intervals 16, 8, 8; release -> no further steps.
3. load 23:59 -> one minute press gives 23:00; one hour press gives 00:00.
4. HOUR_24=0, load 11:30 pm=0 -> hour press gives 12:30 pm=1; next press gives 01:30 pm=1.
5. push2 and push3 fall on the same edge from 09:59 (24h) -> both fields step in the same cycle, result 10:00. Repeat with switch=0 -> time unchanged.
6. Hold push3; assert load 05:05 in a pulse cycle -> 05:05 loaded. Then reset_n low mid-hold -> 00:00, and no step until release plus a new press.
